// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA datapath blocks.
//   RSA_WIDTH   default operand width
//   pp_state_t  post_processing FSM state encoding
//   cnt_width   bit width of a counter that must hold the value w
package rsa_pkg;

    localparam int RSA_WIDTH = 256;

    typedef enum logic [1:0] {
        PP_IDLE   = 2'd0,
        PP_REDUCE = 2'd1,
        PP_FINAL  = 2'd2,
        PP_DONE   = 2'd3
    } pp_state_t;

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/mont_halve_step.sv
// One bit-serial Montgomery reduction step: (acc + (acc odd ? n : 0)) / 2.
// Purely combinational. The sum is formed one bit wider than acc so the
// carry survives the halving.
//   acc       in   WIDTH+1   running accumulator
//   n         in   WIDTH     odd modulus
//   acc_next  out  WIDTH+1   halved accumulator
module mont_halve_step #(
    parameter int WIDTH = rsa_pkg::RSA_WIDTH
) (
    input  logic [WIDTH:0]   acc,
    input  logic [WIDTH-1:0] n,
    output logic [WIDTH:0]   acc_next
);

    logic [WIDTH+1:0] sum;

    always_comb begin
        sum      = {1'b0, acc} + {2'b00, (acc[0] ? n : {WIDTH{1'b0}})};
        acc_next = sum[WIDTH+1:1];
    end

endmodule

// File: rtl/post_processing.sv
// Montgomery-domain exit stage: out = X * 2^-WIDTH mod N, computed by WIDTH
// halve-and-add steps followed by one conditional subtract.
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   beg        start request; loads X and N
//   X          Montgomery-form input value
//   N          odd modulus
//   out        result, held from out_ready until the next completion
//   out_ready  one-cycle valid pulse
//   busy       high from accepted start through the out_ready cycle
//
// state      | meaning
// -----------+-----------------------------------------------------------
// PP_IDLE    | waiting for beg
// PP_REDUCE  | WIDTH halve-and-add steps, cnt counts 0..WIDTH-1
// PP_FINAL   | conditional subtract of N, result registered into out
// PP_DONE    | out_ready high; beg here starts the next operation at once
module post_processing
    import rsa_pkg::*;
#(
    parameter int WIDTH = RSA_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             beg,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] N,
    output logic [WIDTH-1:0] out,
    output logic             out_ready,
    output logic             busy
);

    localparam int            CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    pp_state_t        state;
    pp_state_t        state_nxt;
    logic [WIDTH:0]   acc;
    logic [WIDTH:0]   acc_half;
    logic [WIDTH:0]   acc_fin;
    logic [WIDTH-1:0] n_reg;
    logic [CW-1:0]    cnt;
    logic             start;

    mont_halve_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc),
        .n        (n_reg),
        .acc_next (acc_half)
    );

    // Accepting beg in DONE as well as IDLE gives back-to-back operations
    // every WIDTH+2 cycles.
    assign start = beg && ((state == PP_IDLE) || (state == PP_DONE));

    // acc never exceeds n_reg after the reduction, so one subtract suffices.
    assign acc_fin = (acc >= {1'b0, n_reg}) ? (acc - {1'b0, n_reg}) : acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= PP_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            PP_IDLE:   if (beg) state_nxt = PP_REDUCE;
            PP_REDUCE: if (cnt == CNT_LAST) state_nxt = PP_FINAL;
            PP_FINAL:  state_nxt = PP_DONE;
            PP_DONE:   state_nxt = beg ? PP_REDUCE : PP_IDLE;
            default:   state_nxt = PP_IDLE;
        endcase
    end

    always_comb begin
        out_ready = (state == PP_DONE);
        busy      = (state != PP_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            n_reg <= '0;
            cnt   <= '0;
            out   <= '0;
        end else begin
            if (start) begin
                acc   <= {1'b0, X};
                n_reg <= N;
                cnt   <= '0;
            end else if (state == PP_REDUCE) begin
                acc <= acc_half;
                cnt <= cnt + 1'b1;
            end else if (state == PP_FINAL) begin
                acc <= acc_fin;
                out <= acc_fin[WIDTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_post_processing.sv
module tb_post_processing;

    logic         clk = 1'b0;
    logic         rst;

    logic         beg_a;
    logic [3:0]   x_a, n_a, out_a;
    logic         rdy_a, busy_a;

    logic         beg_b;
    logic [255:0] x_b, n_b, out_b;
    logic         rdy_b, busy_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    post_processing #(.WIDTH(4)) dut_a (
        .clk(clk), .rst(rst), .beg(beg_a), .X(x_a), .N(n_a),
        .out(out_a), .out_ready(rdy_a), .busy(busy_a)
    );

    post_processing #(.WIDTH(256)) dut_b (
        .clk(clk), .rst(rst), .beg(beg_b), .X(x_b), .N(n_b),
        .out(out_b), .out_ready(rdy_b), .busy(busy_b)
    );

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference: the unique r < n with r * 2^4 == x (mod n), n odd.
    function automatic int ref4(input int x, input int n);
        for (int r = 0; r < n; r++)
            if (((r * 16) % n) == (x % n)) return r;
        return -1;
    endfunction

    // Reference entry into Montgomery form: m * 2^256 mod n, m < n.
    function automatic logic [255:0] to_mont(input logic [255:0] m, input logic [255:0] n);
        logic [256:0] r;
        r = {1'b0, m};
        for (int i = 0; i < 256; i++) begin
            r = r << 1;
            if (r >= {1'b0, n}) r = r - {1'b0, n};
        end
        return r[255:0];
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Single start pulse on the WIDTH=4 instance; checks latency, result and busy span.
    task automatic run_a(input int x, input int n, input string tag);
        int k;
        int busy_cyc;
        beg_a = 1'b1; x_a = 4'(x); n_a = 4'(n);
        tick;
        beg_a = 1'b0;
        k = 1;
        busy_cyc = 0;
        while (!rdy_a && k < 20) begin
            if (busy_a) busy_cyc++;
            tick;
            k++;
        end
        if (busy_a) busy_cyc++;
        chk({tag, " latency"}, 256'(k), 256'(6));
        if ((n % 2) == 1) chk({tag, " out"}, 256'(out_a), 256'(ref4(x, n)));
        tick;
        chk({tag, " busy_cycles"}, 256'(busy_cyc), 256'(6));
        chk({tag, " idle_busy"}, 256'(busy_a), 256'(0));
        chk({tag, " idle_rdy"}, 256'(rdy_a), 256'(0));
    endtask

    task automatic run_b(input logic [255:0] m, input logic [255:0] n, input string tag);
        int k;
        beg_b = 1'b1; x_b = to_mont(m, n); n_b = n;
        tick;
        beg_b = 1'b0;
        k = 1;
        while (!rdy_b && k < 300) begin
            tick;
            k++;
        end
        chk({tag, " latency"}, 256'(k), 256'(258));
        chk({tag, " out"}, out_b, m);
        tick;
    endtask

    initial begin
        int last;
        int pulses;
        logic [255:0] nr, mr;

        rst = 1'b1;
        beg_a = 1'b0; x_a = '0; n_a = '0;
        beg_b = 1'b0; x_b = '0; n_b = '0;
        tick; tick;
        chk("reset out_a", 256'(out_a), 256'(0));
        chk("reset rdy_a", 256'(rdy_a), 256'(0));
        chk("reset busy_a", 256'(busy_a), 256'(0));
        chk("reset out_b", out_b, 256'(0));
        rst = 1'b0;
        tick;

        // Directed small-width cases
        run_a(1, 13, "x1_n13");
        chk("x1_n13 hold", 256'(out_a), 256'(9));
        run_a(13, 13, "x13_n13");
        run_a(0, 13, "x0_n13");
        run_a(15, 13, "x15_n13");
        run_a(5, 12, "even_n");

        for (int i = 0; i < 10; i++)
            run_a(int'($urandom_range(0, 15)), int'($urandom_range(1, 7)) * 2 + 1, "rand4");

        // Starts while busy are ignored
        beg_a = 1'b1; x_a = 4'd1; n_a = 4'd13;
        tick;                               // cycle 1
        beg_a = 1'b0;
        tick;                               // cycle 2
        beg_a = 1'b1; x_a = 4'd7;
        tick;                               // cycle 3
        beg_a = 1'b0;
        tick;                               // cycle 4
        beg_a = 1'b1;
        tick;                               // cycle 5
        beg_a = 1'b0;
        chk("ignore rdy_early", 256'(rdy_a), 256'(0));
        tick;                               // cycle 6
        chk("ignore rdy", 256'(rdy_a), 256'(1));
        chk("ignore out", 256'(out_a), 256'(9));
        tick;
        chk("ignore idle_busy", 256'(busy_a), 256'(0));
        chk("ignore out_hold", 256'(out_a), 256'(9));
        run_a(7, 13, "x7_n13");
        chk("x7_n13 value", 256'(out_a), 256'(11));

        // Reset mid-operation
        beg_a = 1'b1; x_a = 4'd1; n_a = 4'd13;
        tick;
        beg_a = 1'b0;
        tick; tick;                         // cycle 3
        rst = 1'b1;
        #1;
        chk("rst out", 256'(out_a), 256'(0));
        chk("rst rdy", 256'(rdy_a), 256'(0));
        chk("rst busy", 256'(busy_a), 256'(0));
        tick;
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick;
            if (rdy_a) pulses++;
        end
        chk("rst no_pulse", 256'(pulses), 256'(0));
        run_a(1, 13, "after_rst");

        // beg held high: back-to-back operations
        beg_a = 1'b1; x_a = 4'd1; n_a = 4'd13;
        last = 0;
        pulses = 0;
        for (int k = 1; k <= 30; k++) begin
            tick;
            if (rdy_a) begin
                chk("held period", 256'(k - last), 256'(6));
                last = k;
                pulses++;
            end
            if (k >= 6) chk("held out", 256'(out_a), 256'(9));
        end
        chk("held pulses", 256'(pulses), 256'(5));
        beg_a = 1'b0;
        for (int i = 0; i < 8; i++) tick;
        chk("held idle", 256'(busy_a), 256'(0));

        // Full-width round trips
        nr = 256'd0;
        nr[255] = 1'b1;
        nr = nr + 256'd95;
        run_b(256'd5, nr, "rt_m5");
        for (int i = 0; i < 50; i++) begin
            nr = rand256();
            nr[0] = 1'b1;
            mr = rand256() % nr;
            run_b(mr, nr, "rt_rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
